// File: rtl/pcie_tx_st_ready_latency_buf_if.sv
// rtl/pcie_tx_st_ready_latency_buf_if.sv - application and core TX streaming handshake bundle
interface pcie_tx_st_ready_latency_buf_if #(
    parameter int DATA_W = 64
);
    logic              app_valid;
    logic              app_ready;
    logic [DATA_W-1:0] app_data;
    logic              app_sop;
    logic              app_eop;
    logic              app_err;

    logic              tx_st_ready0;
    logic              tx_st_valid0;
    logic [DATA_W-1:0] tx_st_data0;
    logic              tx_st_sop0;
    logic              tx_st_eop0;
    logic              tx_st_err0;

    // master: application + core side driving the buffer; slave: the buffer itself
    modport master (
        output app_valid, app_data, app_sop, app_eop, app_err, tx_st_ready0,
        input  app_ready, tx_st_valid0, tx_st_data0, tx_st_sop0, tx_st_eop0, tx_st_err0
    );

    modport slave (
        input  app_valid, app_data, app_sop, app_eop, app_err, tx_st_ready0,
        output app_ready, tx_st_valid0, tx_st_data0, tx_st_sop0, tx_st_eop0, tx_st_err0
    );
endinterface

// File: rtl/pcie_tx_st_ready_latency_buf.sv
// rtl/pcie_tx_st_ready_latency_buf.sv - zero-latency to ready-latency TX staging FIFO with framing check
module pcie_tx_st_ready_latency_buf #(
    parameter int DATA_W        = 64,
    parameter int READY_LATENCY = 2,
    parameter int DEPTH         = 8
) (
    input  logic                     clk_in,
    input  logic                     srst,
    pcie_tx_st_ready_latency_buf_if.slave bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     framing_err,
    output logic [15:0]              pkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 3;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state;
    logic [EW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [READY_LATENCY-1:0] rdy_pipe;
    logic [READY_LATENCY:0]   rdy_shift;
    logic                   rdy_late;
    logic                   push;
    logic                   pop;
    logic                   viol;
    logic [EW-1:0]          head;

    assign bus.app_ready = (count != CW'(DEPTH));
    assign push          = bus.app_valid && bus.app_ready;
    assign rdy_late      = rdy_pipe[READY_LATENCY-1];
    assign pop           = rdy_late && (count != '0);
    assign rdy_shift     = {rdy_pipe, bus.tx_st_ready0};

    // A lost slot (rdy_late with empty FIFO) is simply not used; nothing is sent later for it.
    assign bus.tx_st_valid0 = pop;
    assign head             = mem[rd_ptr];
    assign {bus.tx_st_err0, bus.tx_st_sop0, bus.tx_st_eop0, bus.tx_st_data0} = head;

    assign viol       = push && ((state == IDLE) ? !bus.app_sop : bus.app_sop);
    assign fifo_count = count;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {bus.app_err | viol, bus.app_sop, bus.app_eop, bus.app_data};
        end
    end

    always_ff @(posedge clk_in) begin
        if (srst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rdy_pipe  <= '0;
            pkt_count <= '0;
        end else begin
            rdy_pipe <= rdy_shift[READY_LATENCY-1:0];
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head[DATA_W]) begin
                    pkt_count <= pkt_count + 16'd1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Violating beats are still queued (with err forced); the state follows the beat's eop.
    always_ff @(posedge clk_in) begin
        if (srst) begin
            state       <= IDLE;
            framing_err <= 1'b0;
        end else if (push) begin
            if (viol) begin
                framing_err <= 1'b1;
            end
            case (state)
                IDLE:    state <= (bus.app_sop && !bus.app_eop) ? IN_PKT : IDLE;
                IN_PKT:  state <= bus.app_eop ? IDLE : IN_PKT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_tx_st_ready_latency_buf.sv
// tb/tb_pcie_tx_st_ready_latency_buf.sv - randomized self-checking bench with queue reference model
module tb_pcie_tx_st_ready_latency_buf;
    localparam int DW = 64;
    localparam int RL = 2;
    localparam int D  = 8;

    typedef logic [DW+2:0] beat_t;

    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  fifo_count;
    logic        framing_err;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    pcie_tx_st_ready_latency_buf_if #(.DATA_W(DW)) bus ();

    pcie_tx_st_ready_latency_buf #(
        .DATA_W(DW), .READY_LATENCY(RL), .DEPTH(D)
    ) dut (
        .clk_in      (clk),
        .srst        (srst),
        .bus         (bus),
        .fifo_count  (fifo_count),
        .framing_err (framing_err),
        .pkt_count   (pkt_count)
    );

    int total = 0;
    int bad   = 0;

    // reference model: queue of expected beats plus history of sampled core ready
    beat_t exp_q[$];
    bit    hist[$];
    bit    m_in_pkt;
    bit    m_ferr;
    int    m_pkts;
    int    n_pops;
    bit    m_push;

    bit    obs_valid, obs_ready, pred_valid, pred_ready;
    beat_t obs_beat, pred_beat;
    int    obs_count;

    task automatic model_reset();
        exp_q.delete();
        hist.delete();
        for (int i = 0; i < RL; i++) hist.push_back(1'b0);
        m_in_pkt = 1'b0;
        m_ferr   = 1'b0;
        m_pkts   = 0;
    endtask

    task automatic set_beat(input bit v, input bit sop, input bit eop, input bit err);
        bus.app_valid = v;
        bus.app_sop   = sop;
        bus.app_eop   = eop;
        bus.app_err   = err;
        bus.app_data  = {$urandom(), $urandom()};
    endtask

    task automatic do_reset();
        srst = 1'b1;
        bus.app_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        model_reset();
    endtask

    // samples DUT outputs and model predictions for the current cycle, then advances one clock
    task automatic step();
        bit    pop, viol;
        beat_t b;
        pred_ready = (exp_q.size() != D);
        pred_valid = hist[0] && (exp_q.size() != 0);
        pred_beat  = pred_valid ? exp_q[0] : '0;
        obs_valid  = bus.tx_st_valid0;
        obs_ready  = bus.app_ready;
        obs_beat   = {bus.tx_st_err0, bus.tx_st_sop0, bus.tx_st_eop0, bus.tx_st_data0};
        obs_count  = int'(fifo_count);
        m_push     = bus.app_valid && pred_ready;
        pop        = pred_valid;
        if (pop) begin
            b = exp_q.pop_front();
            if (b[DW]) m_pkts++;
            n_pops++;
        end
        if (m_push) begin
            viol     = m_in_pkt ? bus.app_sop : !bus.app_sop;
            m_ferr   = m_ferr | viol;
            m_in_pkt = m_in_pkt ? !bus.app_eop : (bus.app_sop && !bus.app_eop);
            exp_q.push_back({bus.app_err | viol, bus.app_sop, bus.app_eop, bus.app_data});
        end
        hist.push_back(bus.tx_st_ready0);
        void'(hist.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        bus.tx_st_ready0 = 1'b1;
        set_beat(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.tx_st_valid0 !== 1'b0 || bus.app_ready !== 1'b1 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs valid=%0b ready=%0b count=%0d want 0/1/0", bus.tx_st_valid0, bus.app_ready, fifo_count);
        end
        total++;
        if (framing_err !== 1'b0 || pkt_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_flags ferr=%0b pkts=%0d want 0/0", framing_err, pkt_count);
        end
        srst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_count != 0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d valid=%0b ready=%0b count=%0d want 0/1/0", i, obs_valid, obs_ready, obs_count);
            end
        end
    endtask

    task automatic test_three_beat();
        int first_v, last_v, nv;
        do_reset();
        bus.tx_st_ready0 = 1'b1;
        for (int i = 0; i < RL; i++) step();
        first_v = -1; last_v = -1; nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) set_beat(1'b1, i == 0, i == 2, 1'b0);
            else       bus.app_valid = 1'b0;
            step();
            total++;
            if (obs_valid !== pred_valid) begin
                bad++;
                $display("FAIL three_beat_valid cyc=%0d got=%0b want=%0b", i, obs_valid, pred_valid);
            end
            if (pred_valid) begin
                total++;
                if (obs_beat !== pred_beat) begin
                    bad++;
                    $display("FAIL three_beat_data cyc=%0d got=%h want=%h", i, obs_beat, pred_beat);
                end
            end
            if (obs_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nv++;
            end
        end
        total++;
        if (nv != 3 || last_v - first_v != 2 || first_v != 1) begin
            bad++;
            $display("FAIL three_beat_timing beats=%0d first=%0d last=%0d want 3/1/3", nv, first_v, last_v);
        end
        total++;
        if (pkt_count !== 16'd1 || framing_err !== 1'b0) begin
            bad++;
            $display("FAIL three_beat_counts pkts=%0d ferr=%0b want 1/0", pkt_count, framing_err);
        end
    endtask

    task automatic test_fill_drain();
        int pushes, first_v, p0;
        do_reset();
        bus.tx_st_ready0 = 1'b0;
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            set_beat(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
            step();
            total++;
            if (obs_ready !== pred_ready) begin
                bad++;
                $display("FAIL fill_ready cyc=%0d got=%0b want=%0b", i, obs_ready, pred_ready);
            end
            if (obs_ready && bus.app_valid) pushes++;
        end
        bus.app_valid = 1'b0;
        total++;
        if (pushes != D || fifo_count !== 4'(D) || bus.app_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full pushes=%0d count=%0d ready=%0b want 8/8/0", pushes, fifo_count, bus.app_ready);
        end
        bus.tx_st_ready0 = 1'b1;
        first_v = -1;
        p0 = n_pops;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (obs_valid !== pred_valid) begin
                bad++;
                $display("FAIL drain_valid cyc=%0d got=%0b want=%0b", i, obs_valid, pred_valid);
            end
            if (pred_valid) begin
                total++;
                if (obs_beat !== pred_beat) begin
                    bad++;
                    $display("FAIL drain_data cyc=%0d got=%h want=%h", i, obs_beat, pred_beat);
                end
            end
            if (obs_valid && first_v < 0) first_v = i;
        end
        total++;
        if (first_v != RL || n_pops - p0 != D || pkt_count !== 16'(D)) begin
            bad++;
            $display("FAIL drain_timing first=%0d pops=%0d pkts=%0d want 2/8/8", first_v, n_pops - p0, pkt_count);
        end
    endtask

    task automatic test_toggle();
        int pushed, p0;
        do_reset();
        pushed = 0;
        p0 = n_pops;
        for (int cyc = 0; cyc < 120; cyc++) begin
            bus.tx_st_ready0 = cyc[0];
            if (pushed < 16) set_beat(1'($urandom_range(0, 1)), pushed % 4 == 0, pushed % 4 == 3, 1'b0);
            else             bus.app_valid = 1'b0;
            step();
            if (m_push) pushed++;
            total++;
            if (obs_valid !== pred_valid) begin
                bad++;
                $display("FAIL toggle_valid cyc=%0d got=%0b want=%0b", cyc, obs_valid, pred_valid);
            end
            if (pred_valid) begin
                total++;
                if (obs_beat !== pred_beat) begin
                    bad++;
                    $display("FAIL toggle_data cyc=%0d got=%h want=%h", cyc, obs_beat, pred_beat);
                end
            end
        end
        total++;
        if (n_pops - p0 != 16 || exp_q.size() != 0 || framing_err !== 1'b0 || pkt_count !== 16'd4) begin
            bad++;
            $display("FAIL toggle_totals pops=%0d left=%0d ferr=%0b pkts=%0d want 16/0/0/4", n_pops - p0, exp_q.size(), framing_err, pkt_count);
        end
    endtask

    task automatic test_framing();
        int nv;
        do_reset();
        bus.tx_st_ready0 = 1'b0;
        set_beat(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        total++;
        if (framing_err !== 1'b0) begin
            bad++;
            $display("FAIL framing_first got=%0b want=0", framing_err);
        end
        set_beat(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bus.app_valid = 1'b0;
        total++;
        if (framing_err !== m_ferr || framing_err !== 1'b1) begin
            bad++;
            $display("FAIL framing_second got=%0b want=1", framing_err);
        end
        bus.tx_st_ready0 = 1'b1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_valid) begin
                total++;
                if (obs_beat !== pred_beat || obs_beat[DW+2] !== (nv == 1)) begin
                    bad++;
                    $display("FAIL framing_err_bit beat=%0d got=%h want=%h", nv, obs_beat, pred_beat);
                end
                nv++;
            end
        end
        total++;
        if (nv != 2) begin
            bad++;
            $display("FAIL framing_beats got=%0d want=2", nv);
        end
        bus.tx_st_ready0 = 1'b0;
        set_beat(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.app_valid = 1'b0;
        bus.tx_st_ready0 = 1'b1;
        do_reset();
        total++;
        if (framing_err !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL framing_reset ferr=%0b count=%0d want 0/0", framing_err, fifo_count);
        end
        for (int i = 0; i < RL; i++) begin
            step();
            total++;
            if (obs_valid !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_valid cyc=%0d got=%0b want=0", i, obs_valid);
            end
        end
        set_beat(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        bus.app_valid = 1'b0;
        step();
        total++;
        if (framing_err !== 1'b0 || obs_valid !== 1'b1 || obs_beat !== pred_beat) begin
            bad++;
            $display("FAIL post_reset_pkt ferr=%0b valid=%0b got=%h want 0/1/%h", framing_err, obs_valid, obs_beat, pred_beat);
        end
    endtask

    task automatic test_wrap();
        int pushed, cyc, seen_full_pop;
        do_reset();
        bus.tx_st_ready0 = 1'b1;
        pushed = 0;
        cyc = 0;
        while ((pushed < 65536 || exp_q.size() != 0) && cyc < 70000) begin
            if (pushed < 65536) set_beat(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
            else                bus.app_valid = 1'b0;
            step();
            if (m_push) pushed++;
            cyc++;
            total++;
            if (obs_valid !== pred_valid || (pred_valid && obs_beat !== pred_beat)) begin
                bad++;
                $display("FAIL wrap_beat cyc=%0d valid=%0b got=%h want %0b/%h", cyc, obs_valid, obs_beat, pred_valid, pred_beat);
            end
            if (m_pkts == 65535 && pred_valid) begin
                total++;
                if (pkt_count !== 16'hFFFF) begin
                    bad++;
                    $display("FAIL wrap_ffff got=%h want=ffff", pkt_count);
                end
            end
        end
        total++;
        if (exp_q.size() != 0 || pkt_count !== 16'(m_pkts) || pkt_count !== 16'd0) begin
            bad++;
            $display("FAIL wrap_zero left=%0d pkts=%h want 0/0000", exp_q.size(), pkt_count);
        end
        bus.tx_st_ready0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_beat(1'b1, 1'b1, 1'b1, 1'b0);
            step();
        end
        bus.tx_st_ready0 = 1'b1;
        seen_full_pop = 0;
        for (int i = 0; i < 6; i++) begin
            set_beat(1'b1, 1'b1, 1'b1, 1'b0);
            step();
            if (pred_valid && !pred_ready) begin
                seen_full_pop++;
                total++;
                if (obs_valid !== 1'b1 || obs_ready !== 1'b0 || obs_count != D) begin
                    bad++;
                    $display("FAIL full_pushpop valid=%0b ready=%0b count=%0d want 1/0/8", obs_valid, obs_ready, obs_count);
                end
            end
            total++;
            if (obs_valid !== pred_valid || obs_ready !== pred_ready || (pred_valid && obs_beat !== pred_beat)) begin
                bad++;
                $display("FAIL full_stream cyc=%0d valid=%0b ready=%0b want %0b/%0b", i, obs_valid, obs_ready, pred_valid, pred_ready);
            end
        end
        total++;
        if (seen_full_pop == 0 || fifo_count !== 4'(exp_q.size())) begin
            bad++;
            $display("FAIL full_count seen=%0d count=%0d want >0/%0d", seen_full_pop, fifo_count, exp_q.size());
        end
    endtask

    initial begin
        n_pops = 0;
        bus.tx_st_ready0 = 1'b0;
        set_beat(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_three_beat();
        test_fill_drain();
        test_toggle();
        test_framing();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
